ieeedrv_trk_sched: RTL and testbench
====================================

// Module: ieeedrv_trk_sched
// PURPOSE
//  Track-buffer scheduler for the 4040/8250 drive. Watches the track each subdrive's
//  stepper requests, writes back a dirty buffer to the image, then loads the new track.
//  Serialises all sub-drives through one SD command at a time (round-robin). Owns the
//  per-subdrive sd_lba/sd_blk_cnt/sd_rd/sd_wr/busy/ltrack. Sits between ieeedrv_step and the SD host.
// PARAMETERS
//  SUBDRV   2    number of sub-drives served (1..4)
//  TO_W     24   timeout counter width; timeout = 2**TO_W-1 clk_sys cycles
// PORTS
//  clk_sys       in   1        system clock
//  reset         in   1        synchronous, active-high
//  img_mounted   in   SUBDRV   1-cycle pulse per subdrive: new image mounted
//  img_loaded    in   SUBDRV   level: image present
//  want_trk      in   7xSUBDRV track requested by stepper (0 = none)
//  save_trk      in   SUBDRV   1-cycle pulse: buffer of that subdrive modified
//  tbl_trk       out  7        track index to LBA lookup (combinational table, same cycle)
//  tbl_lba       in   32       first LBA of tbl_trk for current image
//  tbl_cnt       in   6        blocks in tbl_trk minus 1
//  sd_lba        out  32xSUBDRV LBA presented to SD host
//  sd_blk_cnt    out  6xSUBDRV  block count minus 1
//  sd_rd, sd_wr  out  SUBDRV   request strobes (level, held until ack)
//  sd_ack        in   SUBDRV   SD host acknowledge (high while transferring)
//  busy          out  SUBDRV   subdrive buffer not valid/being transferred
//  ltrack        out  8xSUBDRV track currently in buffer; 8'hFF = none
//  sd_err        out  1        sticky: an SD command timed out; cleared by reset/mount
// BEHAVIOUR
//  Reset: all sd_rd/sd_wr=0, sd_lba=0, sd_blk_cnt=0, busy=0, ltrack=8'hFF, dirty=0,
//   rr pointer=0, sd_err=0, FSM=IDLE, timeout=0. Reset mid-transfer abandons it (no write-back).
//  Per subdrive: dirty set by save_trk, cleared when write-back acked; pending =
//   img_loaded & want_trk!=0 & (want_trk!=ltrack[6:0] | ltrack==8'hFF).
//  img_mounted[i]: ltrack[i]=FF, dirty[i]=0, sd_err=0; if i is being served, FSM drops
//   strobes and goes WAITREL (waits sd_ack[i] low) then IDLE.
//  FSM (one subdrive `cur` at a time):
//   IDLE: scan from rr pointer; first i with pending|(dirty & save_trk seen) -> cur=i, SEL.
//    No candidate: stay. Grant order after service: rr=cur+1 mod SUBDRV.
//   SEL: busy[cur]=1. If dirty[cur] & ltrack!=FF: tbl_trk=ltrack, latch lba/cnt -> WR_REQ;
//    else tbl_trk=want_trk, latch -> RD_REQ. Latched values stay on sd_lba/sd_blk_cnt.
//   WR_REQ: sd_wr[cur]=1 until sd_ack[cur]=1 -> WR_XFER (sd_wr drops same cycle ack seen).
//   WR_XFER: wait sd_ack falling -> dirty=0; if pending -> SEL (now reads), else DONE.
//   RD_REQ/RD_XFER: as write with sd_rd; on ack fall ltrack={1'b0,want_trk latched} -> DONE.
//   DONE: busy[cur]=0 (one cycle after ack fall) -> IDLE.
//   WAITREL: strobes 0; on sd_ack[cur]=0 -> IDLE.
//  want_trk change during RD_XFER: completes old read, ltrack=old track, pending re-raised
//   next IDLE; no abort. save_trk during RD_XFER ignored (buffer being overwritten).
//  save_trk during WR_XFER: re-sets dirty after clear (set wins over clear same cycle).
//  Timeout counter runs in *_REQ/*_XFER, clears on state change; at terminal count:
//   strobes 0, sd_err=1, ltrack[cur]=FF, dirty kept, -> WAITREL.
//  Latency: pending seen in IDLE -> sd_rd high 2 cycles later (IDLE->SEL->RD_REQ).
//  Only one bit of sd_rd|sd_wr high at any time (one-hot-or-zero invariant).
// TESTING
//  1) reset; img_loaded=1, want_trk[0]=18, tbl_lba=357 -> sd_rd[0] at +2, sd_lba[0]=357;
//     ack 10 cycles -> ltrack[0]=18, busy[0]=0 one cycle after ack falls.
//  2) ltrack[0]=18, save_trk[0], want_trk=19 -> sd_wr[0] with LBA of trk18 first,
//     then sd_rd with LBA of trk19; dirty clear; ltrack=19.
//  3) both subdrives pending same cycle, rr=0 -> sub0 served then sub1; never both strobes.
//  4) img_mounted[1] during RD_XFER of sub1 -> strobes drop, WAITREL until ack low,
//     ltrack[1]=FF, then reload want_trk[1].
//  5) sd_ack never asserted, TO_W=4 -> after 15 cycles sd_err=1, sd_rd=0, ltrack=FF.
//  6) reset asserted mid WR_XFER -> next cycle all outputs at reset values, dirty=0.

Source files
------------

// File: rtl/ieeedrv_trk_sched_if.sv
// SD host request bundle between the track scheduler and the SD host.
// One lane per sub-drive; the scheduler is the master side.
interface ieeedrv_trk_sched_if #(
  parameter int unsigned SUBDRV = 2
);
  logic [SUBDRV-1:0][31:0] sd_lba;
  logic [SUBDRV-1:0][5:0]  sd_blk_cnt;
  logic [SUBDRV-1:0]       sd_rd;
  logic [SUBDRV-1:0]       sd_wr;
  logic [SUBDRV-1:0]       sd_ack;

  modport master (
    output sd_lba,
    output sd_blk_cnt,
    output sd_rd,
    output sd_wr,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_blk_cnt,
    input  sd_rd,
    input  sd_wr,
    output sd_ack
  );
endinterface

// File: rtl/ieeedrv_trk_sched.sv
// Track-buffer scheduler for the 4040/8250 drive: writes back dirty buffers and loads requested
// tracks, serialising all sub-drives round-robin through a single SD command at a time.
module ieeedrv_trk_sched #(
  parameter int unsigned SUBDRV = 2,
  parameter int unsigned TO_W   = 24
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [SUBDRV-1:0]      img_mounted,
  input  logic [SUBDRV-1:0]      img_loaded,
  input  logic [SUBDRV-1:0][6:0] want_trk,
  input  logic [SUBDRV-1:0]      save_trk,
  output logic [6:0]             tbl_trk,
  input  logic [31:0]            tbl_lba,
  input  logic [5:0]             tbl_cnt,
  ieeedrv_trk_sched_if.master    sd,
  output logic [SUBDRV-1:0]      busy,
  output logic [SUBDRV-1:0][7:0] ltrack,
  output logic                   sd_err
);

  localparam int unsigned IdxW = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;
  // Last counter value before expiry: strobe/transfer may last 2**TO_W-1 cycles.
  localparam logic [TO_W-1:0] ToLast = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StWrReq,
    StWrXfer,
    StRdReq,
    StRdXfer,
    StDone,
    StWaitRel
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         cur_q, cur_d;
  logic [IdxW-1:0]         rr_q, rr_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic [6:0]              rd_trk_q, rd_trk_d;
  logic [SUBDRV-1:0]       dirty_q, dirty_d;
  logic [SUBDRV-1:0]       busy_q, busy_d;
  logic [SUBDRV-1:0][7:0]  ltrack_q, ltrack_d;
  logic [SUBDRV-1:0][31:0] lba_q, lba_d;
  logic [SUBDRV-1:0][5:0]  cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic [SUBDRV-1:0] pending;
  logic [SUBDRV-1:0] wb_cand;
  logic [SUBDRV-1:0] cand;
  logic              found;
  logic [IdxW-1:0]   pick;
  int unsigned       scan_idx;
  logic [IdxW-1:0]   rr_next;
  logic              ack_cur;
  logic              to_run;
  logic [SUBDRV-1:0] rd_strb;
  logic [SUBDRV-1:0] wr_strb;

  always_comb begin
    pending = '0;
    wb_cand = '0;
    for (int unsigned i = 0; i < SUBDRV; i++) begin
      pending[i] = img_loaded[i] && (want_trk[i] != 7'd0) &&
                   ((ltrack_q[i] == 8'hFF) || (want_trk[i] != ltrack_q[i][6:0]));
      wb_cand[i] = dirty_q[i] && (ltrack_q[i] != 8'hFF);
    end
    // A sub-drive being remounted this cycle is not worth starting on.
    cand = (pending | wb_cand) & ~img_mounted;
  end

  // Round-robin scan starting at rr_q.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int unsigned off = 0; off < SUBDRV; off++) begin
      scan_idx = (32'(rr_q) + off) % SUBDRV;
      if (!found && cand[scan_idx]) begin
        found = 1'b1;
        pick  = IdxW'(scan_idx);
      end
    end
  end

  assign rr_next = (cur_q == IdxW'(SUBDRV - 1)) ? '0 : cur_q + 1'b1;
  assign ack_cur = sd.sd_ack[cur_q];

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rr_d     = rr_q;
    rd_trk_d = rd_trk_q;
    dirty_d  = dirty_q;
    busy_d   = busy_q;
    ltrack_d = ltrack_q;
    lba_d    = lba_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    to_d     = '0;
    to_run   = 1'b0;
    tbl_trk  = '0;
    rd_strb  = '0;
    wr_strb  = '0;

    // A save during a read is dropped: the buffer is about to be overwritten.
    for (int unsigned i = 0; i < SUBDRV; i++) begin
      if (save_trk[i] && !(state_q == StRdXfer && cur_q == IdxW'(i))) dirty_d[i] = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          cur_d   = pick;
          state_d = StSel;
        end
      end
      StSel: begin
        busy_d[cur_q] = 1'b1;
        if (dirty_q[cur_q] && (ltrack_q[cur_q] != 8'hFF)) begin
          tbl_trk = ltrack_q[cur_q][6:0];
          state_d = StWrReq;
        end else begin
          tbl_trk  = want_trk[cur_q];
          rd_trk_d = want_trk[cur_q];
          state_d  = StRdReq;
        end
        lba_d[cur_q] = tbl_lba;
        cnt_d[cur_q] = tbl_cnt;
      end
      StWrReq: begin
        to_run         = 1'b1;
        wr_strb[cur_q] = !ack_cur;
        if (ack_cur) state_d = StWrXfer;
      end
      StWrXfer: begin
        to_run = 1'b1;
        if (!ack_cur) begin
          if (!save_trk[cur_q]) dirty_d[cur_q] = 1'b0;
          state_d = pending[cur_q] ? StSel : StDone;
        end
      end
      StRdReq: begin
        to_run         = 1'b1;
        rd_strb[cur_q] = !ack_cur;
        if (ack_cur) state_d = StRdXfer;
      end
      StRdXfer: begin
        to_run = 1'b1;
        if (!ack_cur) begin
          ltrack_d[cur_q] = {1'b0, rd_trk_q};
          state_d         = StDone;
        end
      end
      StDone: begin
        busy_d[cur_q] = 1'b0;
        rr_d          = rr_next;
        state_d       = StIdle;
      end
      StWaitRel: begin
        if (!ack_cur) begin
          busy_d[cur_q] = 1'b0;
          rr_d          = rr_next;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Host never answered (or never released): give up on this buffer.
    if (to_run && (to_q == ToLast)) begin
      err_d           = 1'b1;
      ltrack_d[cur_q] = 8'hFF;
      dirty_d[cur_q]  = dirty_q[cur_q];
      state_d         = StWaitRel;
    end

    for (int unsigned i = 0; i < SUBDRV; i++) begin
      if (img_mounted[i]) begin
        ltrack_d[i] = 8'hFF;
        dirty_d[i]  = 1'b0;
        err_d       = 1'b0;
        if (state_q != StIdle && cur_q == IdxW'(i)) begin
          rd_strb = '0;
          wr_strb = '0;
          state_d = StWaitRel;
        end
      end
    end

    to_d = (to_run && state_d == state_q) ? to_q + TO_W'(1) : '0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      rr_q     <= '0;
      to_q     <= '0;
      rd_trk_q <= '0;
      dirty_q  <= '0;
      busy_q   <= '0;
      ltrack_q <= {SUBDRV{8'hFF}};
      lba_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      rr_q     <= rr_d;
      to_q     <= to_d;
      rd_trk_q <= rd_trk_d;
      dirty_q  <= dirty_d;
      busy_q   <= busy_d;
      ltrack_q <= ltrack_d;
      lba_q    <= lba_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign sd.sd_rd      = rd_strb;
  assign sd.sd_wr      = wr_strb;
  assign sd.sd_lba     = lba_q;
  assign sd.sd_blk_cnt = cnt_q;
  assign busy          = busy_q;
  assign ltrack        = ltrack_q;
  assign sd_err        = err_q;

endmodule

// File: tb/tb_ieeedrv_trk_sched.sv
// Directed bench for ieeedrv_trk_sched: two sub-drives, 4-bit timeout, table LBA = 20*trk-3.
module tb_ieeedrv_trk_sched;

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic [1:0]       img_mounted = '0;
  logic [1:0]       img_loaded  = '0;
  logic [1:0][6:0]  want_trk    = '0;
  logic [1:0]       save_trk    = '0;
  logic [6:0]       tbl_trk;
  logic [31:0]      tbl_lba;
  logic [5:0]       tbl_cnt;
  logic [1:0]       busy;
  logic [1:0][7:0]  ltrack;
  logic             sd_err;

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  bit ok;

  ieeedrv_trk_sched_if #(.SUBDRV(2)) sd ();

  ieeedrv_trk_sched #(.SUBDRV(2), .TO_W(4)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .img_mounted (img_mounted),
    .img_loaded  (img_loaded),
    .want_trk    (want_trk),
    .save_trk    (save_trk),
    .tbl_trk     (tbl_trk),
    .tbl_lba     (tbl_lba),
    .tbl_cnt     (tbl_cnt),
    .sd          (sd.master),
    .busy        (busy),
    .ltrack      (ltrack),
    .sd_err      (sd_err)
  );

  // Track table: trk18 -> 357, trk19 -> 377, trk5 -> 97, trk7 -> 137, trk30 -> 597, trk9 -> 177.
  assign tbl_lba = (32'(tbl_trk) * 32'd20) - 32'd3;
  assign tbl_cnt = tbl_trk[5:0];

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if ($countones({sd.sd_wr, sd.sd_rd}) > 1) viol++;
  end

  initial begin
    sd.sd_ack = '0;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Waits (bounded) until {sd_wr, sd_rd} equals mask.
  task automatic wait_strobe(input logic [3:0] mask, input int budget, output bit hit);
    hit = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (!hit && {sd.sd_wr, sd.sd_rd} === mask) hit = 1'b1;
      if (!hit) tick();
    end
    if (!hit && {sd.sd_wr, sd.sd_rd} === mask) hit = 1'b1;
  endtask

  // Ack held len cycles; returns right after the edge that sees ack fall.
  task automatic serve(input int idx, input int len);
    sd.sd_ack[idx] = 1'b1;
    for (int n = 0; n < len; n++) tick();
    sd.sd_ack[idx] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({sd.sd_wr, sd.sd_rd} !== 4'b0) $display("FAIL rst_strobes got %b want 0000", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    n_checks++; if (busy !== 2'b00) $display("FAIL rst_busy got %b want 00", busy); else n_pass++;
    n_checks++; if (ltrack !== 16'hFFFF) $display("FAIL rst_ltrack got %h want ffff", ltrack); else n_pass++;
    n_checks++; if (sd_err !== 1'b0) $display("FAIL rst_err got %b want 0", sd_err); else n_pass++;
    n_checks++; if (sd.sd_lba !== 64'd0) $display("FAIL rst_lba got %h want 0", sd.sd_lba); else n_pass++;
  endtask

  task automatic test_read();
    img_loaded  = 2'b01;
    want_trk[0] = 7'd18;
    tick();
    n_checks++; if (sd.sd_rd !== 2'b00) $display("FAIL rd_early got %b want 00", sd.sd_rd); else n_pass++;
    tick();
    n_checks++; if (sd.sd_rd !== 2'b01) $display("FAIL rd_latency got %b want 01", sd.sd_rd); else n_pass++;
    n_checks++; if (sd.sd_lba[0] !== 32'd357) $display("FAIL rd_lba got %0d want 357", sd.sd_lba[0]); else n_pass++;
    n_checks++; if (sd.sd_blk_cnt[0] !== 6'd18) $display("FAIL rd_cnt got %0d want 18", sd.sd_blk_cnt[0]); else n_pass++;
    n_checks++; if (busy[0] !== 1'b1) $display("FAIL rd_busy got %b want 1", busy[0]); else n_pass++;
    sd.sd_ack[0] = 1'b1;
    #1;
    n_checks++; if (sd.sd_rd !== 2'b00) $display("FAIL rd_drop_on_ack got %b want 00", sd.sd_rd); else n_pass++;
    for (int n = 0; n < 10; n++) tick();
    sd.sd_ack[0] = 1'b0;
    tick();
    n_checks++; if (ltrack[0] !== 8'd18) $display("FAIL rd_ltrack got %0d want 18", ltrack[0]); else n_pass++;
    n_checks++; if (busy[0] !== 1'b1) $display("FAIL rd_busy_done got %b want 1", busy[0]); else n_pass++;
    tick();
    n_checks++; if (busy[0] !== 1'b0) $display("FAIL rd_busy_clear got %b want 0", busy[0]); else n_pass++;
  endtask

  task automatic test_writeback();
    save_trk[0] = 1'b1;
    want_trk[0] = 7'd19;
    tick();
    save_trk[0] = 1'b0;
    tick();
    n_checks++; if ({sd.sd_wr, sd.sd_rd} !== 4'b0100) $display("FAIL wb_wr_first got %b want 0100", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    n_checks++; if (sd.sd_lba[0] !== 32'd357) $display("FAIL wb_lba got %0d want 357", sd.sd_lba[0]); else n_pass++;
    serve(0, 3);
    tick();
    n_checks++; if ({sd.sd_wr, sd.sd_rd} !== 4'b0001) $display("FAIL wb_rd_next got %b want 0001", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    n_checks++; if (sd.sd_lba[0] !== 32'd377) $display("FAIL wb_rd_lba got %0d want 377", sd.sd_lba[0]); else n_pass++;
    n_checks++; if (sd.sd_blk_cnt[0] !== 6'd19) $display("FAIL wb_rd_cnt got %0d want 19", sd.sd_blk_cnt[0]); else n_pass++;
    serve(0, 2);
    n_checks++; if (ltrack[0] !== 8'd19) $display("FAIL wb_ltrack got %0d want 19", ltrack[0]); else n_pass++;
    for (int n = 0; n < 4; n++) tick();
    n_checks++; if ({sd.sd_wr, sd.sd_rd} !== 4'b0000) $display("FAIL wb_dirty_clear got %b want 0000", {sd.sd_wr, sd.sd_rd}); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    viol        = 0;
    img_loaded  = 2'b11;
    want_trk[0] = 7'd5;
    want_trk[1] = 7'd7;
    wait_strobe(4'b0001, 4, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rr_sub0_first got %b want 0001", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    n_checks++; if (sd.sd_lba[0] !== 32'd97) $display("FAIL rr_lba0 got %0d want 97", sd.sd_lba[0]); else n_pass++;
    serve(0, 2);
    wait_strobe(4'b0010, 6, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rr_sub1_second got %b want 0010", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    n_checks++; if (sd.sd_lba[1] !== 32'd137) $display("FAIL rr_lba1 got %0d want 137", sd.sd_lba[1]); else n_pass++;
    serve(1, 2);
    tick();
    n_checks++; if (ltrack !== {8'd7, 8'd5}) $display("FAIL rr_ltrack got %h want 0705", ltrack); else n_pass++;
    n_checks++; if (viol !== 0) $display("FAIL rr_onehot got %0d want 0", viol); else n_pass++;
  endtask

  task automatic test_mount_abort();
    want_trk[1] = 7'd30;
    wait_strobe(4'b0010, 5, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL mnt_rd got %b want 0010", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    sd.sd_ack[1] = 1'b1;
    tick();
    tick();
    img_mounted = 2'b10;
    tick();
    img_mounted = 2'b00;
    n_checks++; if (ltrack[1] !== 8'hFF) $display("FAIL mnt_ltrack got %h want ff", ltrack[1]); else n_pass++;
    tick();
    tick();
    n_checks++; if ({sd.sd_wr, sd.sd_rd} !== 4'b0000) $display("FAIL mnt_waitrel got %b want 0000", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    sd.sd_ack[1] = 1'b0;
    tick();
    wait_strobe(4'b0010, 5, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL mnt_reload got %b want 0010", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    n_checks++; if (sd.sd_lba[1] !== 32'd597) $display("FAIL mnt_lba got %0d want 597", sd.sd_lba[1]); else n_pass++;
    serve(1, 2);
    n_checks++; if (ltrack[1] !== 8'd30) $display("FAIL mnt_ltrack_new got %0d want 30", ltrack[1]); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    want_trk[0] = 7'd9;
    wait_strobe(4'b0001, 5, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL to_rd got %b want 0001", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    for (int n = 0; n < 14; n++) tick();
    n_checks++; if ({sd_err, sd.sd_rd} !== 3'b001) $display("FAIL to_early got err,rd=%b want 001", {sd_err, sd.sd_rd}); else n_pass++;
    tick();
    n_checks++; if (sd_err !== 1'b1) $display("FAIL to_err got %b want 1", sd_err); else n_pass++;
    n_checks++; if (sd.sd_rd !== 2'b00) $display("FAIL to_rd_drop got %b want 00", sd.sd_rd); else n_pass++;
    n_checks++; if (ltrack[0] !== 8'hFF) $display("FAIL to_ltrack got %h want ff", ltrack[0]); else n_pass++;
    img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00;
    n_checks++; if (sd_err !== 1'b0) $display("FAIL to_err_mount got %b want 0", sd_err); else n_pass++;
    img_loaded = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    img_loaded  = 2'b01;
    want_trk[0] = 7'd18;
    wait_strobe(4'b0001, 5, ok);
    serve(0, 2);
    tick();
    save_trk[0] = 1'b1;
    tick();
    save_trk[0] = 1'b0;
    wait_strobe(4'b0100, 4, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rmw_wr got %b want 0100", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    sd.sd_ack[0] = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if ({sd.sd_wr, sd.sd_rd, busy, sd_err} !== 7'b0) $display("FAIL rmw_outs got %b want 0000000", {sd.sd_wr, sd.sd_rd, busy, sd_err}); else n_pass++;
    n_checks++; if (ltrack !== 16'hFFFF) $display("FAIL rmw_ltrack got %h want ffff", ltrack); else n_pass++;
    n_checks++; if ({sd.sd_lba, sd.sd_blk_cnt} !== 76'd0) $display("FAIL rmw_lba got %h want 0", {sd.sd_lba, sd.sd_blk_cnt}); else n_pass++;
    sd.sd_ack[0] = 1'b0;
    tick();
    reset = 1'b0;
    wait_strobe(4'b0001, 5, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rmw_reload got %b want 0001", {sd.sd_wr, sd.sd_rd}); else n_pass++;
    serve(0, 2);
    for (int n = 0; n < 4; n++) tick();
    n_checks++; if (sd.sd_wr !== 2'b00) $display("FAIL rmw_dirty got %b want 00", sd.sd_wr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_writeback();
    test_round_robin();
    test_mount_abort();
    test_timeout();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
